// File: rtl/squid_pkg.sv
// Shared constants, types and SQUID coding functions for the streaming block decoder.
// Each weight carries a Hamming-style check word (vp); pp protects the vp words of a block.
package squid_pkg;

    localparam int WB_N = 8;
    localparam int W_W  = 6;
    localparam int VP_W = 4;
    localparam int PP_N = 4;
    localparam int PP_W = 4;

    typedef logic [W_W-1:0]  weight_t;
    typedef logic [VP_W-1:0] vp_t;
    typedef logic [PP_W-1:0] pp_t;
    typedef weight_t [WB_N-1:0] block_t;
    typedef vp_t     [WB_N-1:0] vp_blk_t;
    typedef pp_t     [PP_N-1:0] pp_blk_t;

    // Weight bit i occupies a non-power-of-two Hamming position, so every bit touches >= 2 vp bits.
    function automatic vp_t data_pos(input int i);
        case (i)
            0:       return 4'd3;
            1:       return 4'd5;
            2:       return 4'd6;
            3:       return 4'd7;
            4:       return 4'd9;
            default: return 4'd10;
        endcase
    endfunction

    function automatic vp_t first_level_encoder(input weight_t w);
        vp_t vp;
        vp = '0;
        for (int i = 0; i < W_W; i++) begin
            if (w[i]) vp = vp ^ data_pos(i);
        end
        return vp;
    endfunction

    // pp[0] is the XOR of all vp words; pp[b+1] covers the weights whose index has bit b set.
    function automatic vp_blk_t second_level_decoder(input vp_blk_t vp, input pp_blk_t pp);
        vp_blk_t          rec;
        vp_t              err;
        pp_t              syn;
        logic [PP_N-2:0]  loc;
        rec = vp;
        err = pp[0];
        loc = '0;
        for (int i = 0; i < WB_N; i++) err = err ^ vp[i];
        for (int b = 0; b < PP_N - 1; b++) begin
            syn = pp[b+1];
            for (int i = 0; i < WB_N; i++) begin
                if (i[b]) syn = syn ^ vp[i];
            end
            loc[b] = |syn;
        end
        if (err != '0) rec[loc] = rec[loc] ^ err;
        return rec;
    endfunction

    function automatic weight_t first_level_decoder(input weight_t w, input vp_t vp_rec);
        vp_t     syn;
        weight_t fixed;
        syn   = first_level_encoder(w) ^ vp_rec;
        fixed = w;
        for (int i = 0; i < W_W; i++) begin
            if (syn == data_pos(i)) fixed[i] = ~fixed[i];
        end
        return fixed;
    endfunction

    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input logic [63:0] max);
        logic [63:0] sum;
        sum = a + b;
        return (sum > max) ? max : sum;
    endfunction

endpackage

// File: rtl/squid_dec_lane.sv
// Combinational datapath of one lane: vp generation for stage 1, vp recovery and weight
// correction for stage 2. All registers live in the top.
module squid_dec_lane
    import squid_pkg::*;
(
    input  block_t  s1_weights,
    output vp_blk_t s1_vp,
    input  block_t  s2_weights,
    input  vp_blk_t s2_vp,
    input  pp_blk_t s2_pp,
    input  logic    s2_bypass,
    output block_t  s2_dec_weights,
    output logic    s2_corr
);

    vp_blk_t vp_rec;

    always_comb begin
        s1_vp = '0;
        for (int i = 0; i < WB_N; i++) s1_vp[i] = first_level_encoder(s1_weights[i]);
    end

    // Bypass beats keep the stored weights bit-exact and never report a correction.
    always_comb begin
        vp_rec         = second_level_decoder(s2_vp, s2_pp);
        s2_dec_weights = s2_weights;
        s2_corr        = 1'b0;
        if (!s2_bypass) begin
            for (int i = 0; i < WB_N; i++) begin
                s2_dec_weights[i] = first_level_decoder(s2_weights[i], vp_rec[i]);
            end
            s2_corr = (vp_rec != s2_vp);
        end
    end

endmodule

// File: rtl/squid_decoder_stream.sv
// Elastic, handshaked SQUID block decoder: LANES blocks per beat, PIPE_STAGES register stages,
// with bypass, per-lane correction flags and saturating statistics counters.
module squid_decoder_stream
    import squid_pkg::*;
#(
    parameter int LANES       = 2,
    parameter int PIPE_STAGES = 2,
    parameter int CNT_W       = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_bypass,
    input  logic [LANES*WB_N*W_W-1:0]   in_weights,
    input  logic [LANES*PP_N*PP_W-1:0]  in_pp,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*WB_N*W_W-1:0]   out_weights,
    output logic [LANES-1:0]            out_corr,
    output logic                        out_bypass,
    input  logic                        cnt_clr,
    output logic [CNT_W-1:0]            blk_cnt,
    output logic [CNT_W-1:0]            corr_cnt
);

    localparam int BLK_W = WB_N * W_W;
    localparam int VPB_W = WB_N * VP_W;
    localparam int PPB_W = PP_N * PP_W;
    localparam logic [63:0] CNT_MAX = (64'd1 << CNT_W) - 64'd1;

    logic [PIPE_STAGES:1]       vld;
    logic [PIPE_STAGES:1]       rdy;

    logic [LANES*BLK_W-1:0]     s1_w;
    logic [LANES*VPB_W-1:0]     s1_vp;
    logic [LANES*PPB_W-1:0]     s1_pp;
    logic                       s1_byp;

    logic [LANES*VPB_W-1:0]     enc_vp;
    logic [LANES*BLK_W-1:0]     dec_w;
    logic [LANES-1:0]           dec_corr;

    logic [LANES*BLK_W-1:0]     st_w    [2:PIPE_STAGES];
    logic [LANES-1:0]           st_corr [2:PIPE_STAGES];
    logic                       st_byp  [2:PIPE_STAGES];

    logic [3:0]                 corr_pop;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        squid_dec_lane u_lane (
            .s1_weights     (in_weights[l*BLK_W +: BLK_W]),
            .s1_vp          (enc_vp[l*VPB_W +: VPB_W]),
            .s2_weights     (s1_w[l*BLK_W +: BLK_W]),
            .s2_vp          (s1_vp[l*VPB_W +: VPB_W]),
            .s2_pp          (s1_pp[l*PPB_W +: PPB_W]),
            .s2_bypass      (s1_byp),
            .s2_dec_weights (dec_w[l*BLK_W +: BLK_W]),
            .s2_corr        (dec_corr[l])
        );
    end

    // A stage can take new data when it is empty or its content moves on this cycle;
    // the chain runs back combinationally from out_ready so a full pipe still streams.
    always_comb begin
        logic chain;
        chain = out_ready;
        rdy   = '0;
        for (int k = PIPE_STAGES; k >= 1; k--) begin
            chain  = !vld[k] || chain;
            rdy[k] = chain;
        end
    end

    assign in_ready    = rdy[1];
    assign out_valid   = vld[PIPE_STAGES];
    assign out_weights = st_w[PIPE_STAGES];
    assign out_corr    = st_corr[PIPE_STAGES];
    assign out_bypass  = st_byp[PIPE_STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld    <= '0;
            s1_w   <= '0;
            s1_vp  <= '0;
            s1_pp  <= '0;
            s1_byp <= 1'b0;
            for (int k = 2; k <= PIPE_STAGES; k++) begin
                st_w[k]    <= '0;
                st_corr[k] <= '0;
                st_byp[k]  <= 1'b0;
            end
        end else begin
            if (rdy[1]) begin
                vld[1] <= in_valid;
                if (in_valid) begin
                    s1_w   <= in_weights;
                    s1_vp  <= enc_vp;
                    s1_pp  <= in_pp;
                    s1_byp <= in_bypass;
                end
            end
            if (rdy[2]) begin
                vld[2] <= vld[1];
                if (vld[1]) begin
                    st_w[2]    <= dec_w;
                    st_corr[2] <= dec_corr;
                    st_byp[2]  <= s1_byp;
                end
            end
            for (int k = 3; k <= PIPE_STAGES; k++) begin
                if (rdy[k]) begin
                    vld[k] <= vld[k-1];
                    if (vld[k-1]) begin
                        st_w[k]    <= st_w[k-1];
                        st_corr[k] <= st_corr[k-1];
                        st_byp[k]  <= st_byp[k-1];
                    end
                end
            end
        end
    end

    always_comb begin
        corr_pop = '0;
        for (int l = 0; l < LANES; l++) corr_pop = corr_pop + 4'(out_corr[l]);
    end

    // Statistics move only on the output handshake; a simultaneous clear takes priority.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            blk_cnt  <= '0;
            corr_cnt <= '0;
        end else if (out_valid && out_ready) begin
            if (!out_bypass) begin
                blk_cnt <= CNT_W'(sat_add(64'(blk_cnt), 64'(LANES), CNT_MAX));
            end
            corr_cnt <= CNT_W'(sat_add(64'(corr_cnt), 64'(corr_pop), CNT_MAX));
        end
    end

endmodule

// File: doc/squid_decoder_stream.md
Name: squid_decoder_stream

Overview:
- Pipelined, handshaked successor of the combinational SQUID block decoder.
- Accepts LANES weight blocks per beat. Each block is 8 weights x 6 bit plus 4 parity words x 4 bit (pp).
- Recovers the corrected weights using the existing FIRST_LEVEL_ENCODER, SECOND_LEVEL_DECODER and FIRST_LEVEL_DECODER sub-modules.
- Adds a per-beat bypass mode, correction flags and saturating statistics counters. Sits between the weight-buffer read port and the PE array feed.

Parameters:
- LANES, 2, blocks processed per beat (1..8).
- PIPE_STAGES, 2, register stages from input to output (legal 2..4).
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid&&in_ready
- in_bypass  in  1  beat passes through uncorrected
- in_weights  in  LANES*8*6  lane l, weight i at bits [(l*8+i)*6 +: 6]
- in_pp  in  LANES*4*4  lane l, word j at bits [(l*4+j)*4 +: 4]
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_weights  out  LANES*8*6  decoded weights, same packing as in_weights
- out_corr  out  LANES  lane l: vp_recovered != vp for at least one weight
- out_bypass  out  1  bypass bit carried with the beat
- cnt_clr  in  1  synchronous clear of both counters
- blk_cnt  out  CNT_W  decoded (non-bypass) lane-blocks delivered
- corr_cnt  out  CNT_W  delivered lane-blocks with out_corr=1

Behaviour:
- Reset values: all stage valids 0, out_valid=0, out_weights=0, out_corr=0, out_bypass=0, blk_cnt=0, corr_cnt=0. in_ready=1 during the cycle after rst deasserts.
- Reset mid-operation: all in-flight beats are discarded, with no partial output.
- Datapath:
  - Stage 1 computes vp[l][i] via FIRST_LEVEL_ENCODER on in_weights. It registers weights, vp, pp and bypass.
  - Stage 2 runs SECOND_LEVEL_DECODER (vp, pp -> vp_recovered) and FIRST_LEVEL_DECODER (weight, vp_recovered -> output). It registers out_weights and out_corr.
  - Stages 3..PIPE_STAGES are pure delay registers.
- Bypass: out_weights = input weights bit-exact and out_corr = 0. Pp is ignored.
- Elastic pipeline:
  - Stage k loads when stage k+1 is empty or is advancing in the same cycle.
  - The last stage advances on out_valid&&out_ready.
  - in_ready = !s1_valid || s1_advance. This is combinational from out_ready through the stage chain.
  - No bubbles when out_ready is held 1.
- Latency: an accepted beat appears on out_* exactly PIPE_STAGES cycles later if out_ready is held 1. Throughput is 1 beat/cycle.
- Stall: while out_valid&&!out_ready, all out_* stay stable. Up to PIPE_STAGES beats are held and in_ready drops only once all stages are full. No beat is lost or duplicated, and order is preserved.
- Counters update only on the output handshake:
  - blk_cnt += number of lanes when !out_bypass.
  - corr_cnt += popcount(out_corr).
  - Both saturate at 2^CNT_W-1 with no wrap.
- cnt_clr in the same cycle as a handshake: clear wins and the counter becomes 0; that beat is not counted.
- in_valid without in_ready: the beat is not taken, and inputs may change freely.

Decomposition:
- squid_pkg holds:
  - constants WB_N=8, W_W=6, VP_W=4, PP_N=4, PP_W=4;
  - typedefs weight_t [W_W-1:0], vp_t [VP_W-1:0], block_t (weight_t array [WB_N]), pp_blk_t (pp array [PP_N]);
  - function sat_add for the counters.
- Sub-module squid_dec_lane holds one lane's combinational datapath. It exposes a stage-1 port (weights -> vp) and a stage-2 port (weights, vp, pp -> out weights, corr flag) so the top owns all registers and handshake logic. The top generates LANES instances.

Test Plan:
- Zero blocks: LANES=2, weights all 0 with pp from the SQUID encoder model, 1 beat. Expect output all 0 after exactly 2 cycles (PIPE_STAGES=2), out_corr=2'b00, blk_cnt=2, corr_cnt=0.
- Single-bit error: encode weights 0x01..0x08, then flip bit 0 of weight 3 in lane 1. Expect out_weights equal to the originals, out_corr=2'b10, corr_cnt=1.
- Bypass: same corrupted beat with in_bypass=1. Expect out_weights equal the corrupted input, out_corr=0, out_bypass=1, blk_cnt unchanged.
- Backpressure: stream 10 random encoded beats with out_ready toggling 1,0,0,1. Expect in_ready=0 only when 2 beats are held, 10 outputs in order with none dropped, out_* stable during stalls.
- Counter saturation and clear: CNT_W=4, 9 two-lane beats. Expect blk_cnt to stick at 15. cnt_clr together with a handshake gives 0, and the next beat gives 2.
- Reset mid-stream: assert rst with 2 beats in flight. Expect out_valid=0 the next cycle, counters 0, and no stale beat afterwards.
